ldm_stm_seq: RTL and testbench

//  Multi-register load/store sequencer (LDM/STM) for the 32-bit core. Walks a 16-bit register list,
//  one register per memory beat, ascending order at ascending addresses. Drives the register file

---
 rtl/ldm_stm_pkg.sv | 33 +++
 rtl/lowest_set16.sv | 22 ++
 rtl/ldm_stm_seq.sv | 165 ++++++++++++++++
 tb/tb_ldm_stm_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ldm_stm_pkg.sv
// Shared types and helpers for the LDM/STM multi-register sequencer.
package ldm_stm_pkg;

  // Address step between consecutive transferred registers
  localparam int unsigned WORD_BYTES = 4;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WB,
    DONE
  } state_t;

  // Addressing mode, encoded directly as {pre, up}
  typedef enum logic [1:0] {
    DA = 2'b00,
    IA = 2'b01,
    DB = 2'b10,
    IB = 2'b11
  } amode_t;

  // Number of registers named in a 16-bit register list (0..16)
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/lowest_set16.sv
// Priority picker: index of the lowest set bit in a 16-bit mask.
import ldm_stm_pkg::*;

module lowest_set16 (
  input  logic [15:0] mask,
  output logic [3:0]  idx,
  output logic        any
);

  // Scan from the top down so the lowest set bit is the last to win
  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) begin
        idx = 4'(i);
      end
    end
  end

  assign any = |mask;

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM sequencer: walks a register list one memory beat per register,
// ascending registers at ascending addresses, then optionally writes the
// final address back to the base register.
import ldm_stm_pkg::*;

module ldm_stm_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        load,
  input  logic        up,
  input  logic        pre,
  input  logic        wb,
  input  logic [3:0]  rn,
  input  logic [31:0] base,
  input  logic [15:0] reglist,
  output logic        busy,
  output logic        done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  rf_ra,
  input  logic [31:0] rf_rd,
  output logic        rf_we,
  output logic [3:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        pc_we,
  output logic [31:0] pc_wd
);

  state_t      state, state_next;
  logic [15:0] mask_r;
  logic [31:0] addr_r;
  logic [31:0] final_r;
  logic        load_r;
  logic        do_wb_r;
  logic [3:0]  rn_r;

  logic [3:0]  idx;
  logic        any;
  logic [15:0] mask_clr;

  logic [4:0]  n_start;
  logic [31:0] span;
  logic [31:0] first_addr;
  logic [31:0] final_addr;
  amode_t      mode;

  lowest_set16 u_lowest (
    .mask (mask_r),
    .idx  (idx),
    .any  (any)
  );

  assign mask_clr = mask_r & ~(16'h0001 << idx);

  // First beat address and final writeback address from the request fields
  always_comb begin
    n_start = popcount16(reglist);
    span    = 32'(n_start) * 32'(WORD_BYTES);
    mode    = amode_t'({pre, up});
    unique case (mode)
      IA:      first_addr = base;
      IB:      first_addr = base + 32'(WORD_BYTES);
      DA:      first_addr = base - span + 32'(WORD_BYTES);
      DB:      first_addr = base - span;
      default: first_addr = base;
    endcase
    final_addr = up ? (base + span) : (base - span);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request capture at start and per-beat mask/address advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_r  <= '0;
      addr_r  <= '0;
      final_r <= '0;
      load_r  <= 1'b0;
      do_wb_r <= 1'b0;
      rn_r    <= '0;
    end else if (state == IDLE && start) begin
      mask_r  <= reglist;
      addr_r  <= first_addr;
      final_r <= final_addr;
      load_r  <= load;
      rn_r    <= rn;
      do_wb_r <= wb && (rn != 4'd15) && !(load && reglist[rn]);
    end else if (state == XFER && mem_ack) begin
      mask_r  <= mask_clr;
      addr_r  <= addr_r + 32'(WORD_BYTES);
    end
  end

  // Next-state and output decode
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    rf_ra      = '0;
    rf_we      = 1'b0;
    rf_wa      = '0;
    rf_wd      = '0;
    pc_we      = 1'b0;
    pc_wd      = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = (|reglist) ? XFER : DONE;
        end
      end
      XFER: begin
        mem_req  = any;
        mem_we   = ~load_r;
        mem_addr = addr_r;
        rf_ra    = idx;
        if (!load_r) begin
          mem_wdata = rf_rd;
        end
        if (mem_ack) begin
          if (load_r) begin
            if (idx == 4'd15) begin
              pc_we = 1'b1;
              pc_wd = mem_rdata;
            end else begin
              rf_we = 1'b1;
              rf_wa = idx;
              rf_wd = mem_rdata;
            end
          end
          if (mask_clr == 16'h0000) begin
            state_next = do_wb_r ? WB : DONE;
          end
        end
      end
      WB: begin
        rf_we      = 1'b1;
        rf_wa      = rn_r;
        rf_wd      = final_r;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed self-checking bench for the LDM/STM sequencer.
module tb_ldm_stm_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, load, up, pre, wb;
  logic [3:0]  rn;
  logic [31:0] base;
  logic [15:0] reglist;
  logic        busy, done, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  rf_ra, rf_wa;
  logic [31:0] rf_rd, rf_wd, pc_wd;
  logic        rf_we, pc_we;

  int checks = 0;
  int passes = 0;
  int cycle  = 0;
  int t0     = 0;
  int ack_delay = 0;
  int wait_cnt  = 0;

  int          req_cycles;
  int          unstable;
  int          done_rel;
  logic        prev_pending;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_we;
  logic        beat_we[$];
  logic [31:0] beat_addr[$];
  logic [31:0] beat_wdata[$];
  logic [3:0]  rfw_wa[$];
  logic [31:0] rfw_wd[$];
  logic [31:0] pcw[$];

  ldm_stm_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .load      (load),
    .up        (up),
    .pre       (pre),
    .wb        (wb),
    .rn        (rn),
    .base      (base),
    .reglist   (reglist),
    .busy      (busy),
    .done      (done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rf_ra     (rf_ra),
    .rf_rd     (rf_rd),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .pc_we     (pc_we),
    .pc_wd     (pc_wd)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Register file and memory models: data is a fixed function of the address
  assign rf_rd     = 32'hC0DE_0000 | {28'h0, rf_ra};
  assign mem_rdata = mem_addr ^ 32'hA5A5_A5A5;
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);

  // Cycle counter and memory wait-state counter
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  // Passive monitor: logs beats, register writes and completion time
  always @(negedge clk) begin
    if (mem_req) req_cycles++;
    if (prev_pending && (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata))
      unstable++;
    prev_pending = mem_req && !mem_ack;
    prev_addr    = mem_addr;
    prev_we      = mem_we;
    prev_wdata   = mem_wdata;
    if (mem_req && mem_ack) begin
      beat_we.push_back(mem_we);
      beat_addr.push_back(mem_addr);
      beat_wdata.push_back(mem_wdata);
    end
    if (rf_we) begin
      rfw_wa.push_back(rf_wa);
      rfw_wd.push_back(rf_wd);
    end
    if (pc_we) pcw.push_back(pc_wd);
    if (done) done_rel = cycle - t0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic ld, input logic up_i, input logic pre_i, input logic wb_i,
                               input logic [3:0] rn_i, input logic [31:0] base_i,
                               input logic [15:0] list_i, input int delay);
    logic seen;
    @(negedge clk);
    beat_we.delete(); beat_addr.delete(); beat_wdata.delete();
    rfw_wa.delete(); rfw_wd.delete(); pcw.delete();
    req_cycles = 0; unstable = 0; done_rel = -1; prev_pending = 1'b0;
    ack_delay = delay;
    load = ld; up = up_i; pre = pre_i; wb = wb_i; rn = rn_i; base = base_i; reglist = list_i;
    start = 1'b1;
    t0 = cycle;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen = 1'b1;
    end
    checkOutput("done_seen", {31'h0, seen}, 32'd1);
    @(negedge clk);
    checkOutput("idle_after", {31'h0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] q32(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; load = 1'b0; up = 1'b0; pre = 1'b0; wb = 1'b0;
    rn = '0; base = '0; reglist = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",  {31'h0, busy},    32'd0);
    checkOutput("rst_req",   {31'h0, mem_req}, 32'd0);
    checkOutput("rst_rfwe",  {31'h0, rf_we},   32'd0);
    checkOutput("rst_addr",  mem_addr,         32'h0);
    rst_n = 1'b1;

    // STM IA, writeback to r13
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h0000_1000, 16'h0013, 0);
    checkOutput("t1_beats", beat_addr.size(), 32'd3);
    checkOutput("t1_we0",   {31'h0, beat_we.size() > 0 ? beat_we[0] : 1'b0}, 32'd1);
    checkOutput("t1_a0",    q32(beat_addr, 0),  32'h0000_1000);
    checkOutput("t1_a1",    q32(beat_addr, 1),  32'h0000_1004);
    checkOutput("t1_a2",    q32(beat_addr, 2),  32'h0000_1008);
    checkOutput("t1_d0",    q32(beat_wdata, 0), 32'hC0DE_0000);
    checkOutput("t1_d1",    q32(beat_wdata, 1), 32'hC0DE_0001);
    checkOutput("t1_d2",    q32(beat_wdata, 2), 32'hC0DE_0004);
    checkOutput("t1_rfn",   rfw_wa.size(),      32'd1);
    checkOutput("t1_wa",    {28'h0, rfw_wa.size() > 0 ? rfw_wa[0] : 4'hF}, 32'd13);
    checkOutput("t1_wd",    q32(rfw_wd, 0),     32'h0000_100C);
    checkOutput("t1_done",  done_rel,           32'd5);

    // LDM DB including r15, no writeback
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 32'h0000_2000, 16'h8003, 0);
    checkOutput("t2_beats", beat_addr.size(),   32'd3);
    checkOutput("t2_we0",   {31'h0, beat_we.size() > 0 ? beat_we[0] : 1'b1}, 32'd0);
    checkOutput("t2_a0",    q32(beat_addr, 0),  32'h0000_1FF4);
    checkOutput("t2_a1",    q32(beat_addr, 1),  32'h0000_1FF8);
    checkOutput("t2_a2",    q32(beat_addr, 2),  32'h0000_1FFC);
    checkOutput("t2_rfn",   rfw_wa.size(),      32'd2);
    checkOutput("t2_wa0",   {28'h0, rfw_wa.size() > 0 ? rfw_wa[0] : 4'hF}, 32'd0);
    checkOutput("t2_wd0",   q32(rfw_wd, 0),     32'hA5A5_BA51);
    checkOutput("t2_wa1",   {28'h0, rfw_wa.size() > 1 ? rfw_wa[1] : 4'hF}, 32'd1);
    checkOutput("t2_wd1",   q32(rfw_wd, 1),     32'hA5A5_BA5D);
    checkOutput("t2_pcn",   pcw.size(),         32'd1);
    checkOutput("t2_pc",    q32(pcw, 0),        32'hA5A5_BA59);
    checkOutput("t2_done",  done_rel,           32'd4);

    // STM IB single register, three wait states
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0000_3000, 16'h0004, 3);
    checkOutput("t3_beats", beat_addr.size(),   32'd1);
    checkOutput("t3_a0",    q32(beat_addr, 0),  32'h0000_3004);
    checkOutput("t3_d0",    q32(beat_wdata, 0), 32'hC0DE_0002);
    checkOutput("t3_reqc",  req_cycles,         32'd4);
    checkOutput("t3_stable", unstable,          32'd0);
    checkOutput("t3_done",  done_rel,           32'd5);

    // Empty list
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 32'h0000_6000, 16'h0000, 0);
    checkOutput("t4_done",  done_rel,           32'd1);
    checkOutput("t4_reqc",  req_cycles,         32'd0);
    checkOutput("t4_rfn",   rfw_wa.size(),      32'd0);
    checkOutput("t4_pcn",   pcw.size(),         32'd0);

    // LDM IA with base register in the list: loaded value wins, no writeback
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h0000_4000, 16'h0006, 0);
    checkOutput("t5_a0",    q32(beat_addr, 0),  32'h0000_4000);
    checkOutput("t5_a1",    q32(beat_addr, 1),  32'h0000_4004);
    checkOutput("t5_rfn",   rfw_wa.size(),      32'd2);
    checkOutput("t5_wa1",   {28'h0, rfw_wa.size() > 1 ? rfw_wa[1] : 4'hF}, 32'd2);
    checkOutput("t5_wd1",   q32(rfw_wd, 1),     32'hA5A5_E5A1);
    checkOutput("t5_done",  done_rel,           32'd3);

    // Reset during beat 2 of 4, with a start pulse while busy that must be ignored
    @(negedge clk);
    ack_delay = 0;
    load = 1'b0; up = 1'b1; pre = 1'b0; wb = 1'b1; rn = 4'd9; base = 32'h0000_5000; reglist = 16'h000F;
    start = 1'b1;
    @(negedge clk);
    checkOutput("t6_a0",    mem_addr,           32'h0000_5000);
    base = 32'h0000_9000; reglist = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t6_a1",    mem_addr,           32'h0000_5004);
    checkOutput("t6_busy",  {31'h0, busy},      32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t6_rbusy", {31'h0, busy},      32'd0);
    checkOutput("t6_rreq",  {31'h0, mem_req},   32'd0);
    checkOutput("t6_raddr", mem_addr,           32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t6_idle",  {31'h0, busy},      32'd0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
